// File: rtl/rv_ctrl_pkg.sv
// ============================================================================
// Module      : rv_ctrl_pkg
// Description : Shared opcode, ALUOp and control-bundle definitions for the
//               ID-stage main control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_NOP    = 7'b0000000;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/control_decode.sv
// ============================================================================
// Module      : control_decode
// Description : Purely combinational opcode -> control-bundle decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = CTRL_BUBBLE;
        case (i_opcode)
            OP_LOAD: begin
                o_ctrl.alu_op     = ALUOP_ADD;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            OP_STORE: begin
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            OP_RTYPE: begin
                o_ctrl.alu_op    = ALUOP_R;
                o_ctrl.reg_write = 1'b1;
            end
            OP_BRANCH: begin
                o_ctrl.alu_op = ALUOP_SUB;
                o_ctrl.branch = 1'b1;
            end
            OP_IALU: begin
                o_ctrl.alu_op    = ALUOP_I;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            // The all-zero word is a pipeline bubble, not an illegal opcode.
            OP_NOP:  o_ctrl = CTRL_BUBBLE;
            default: o_ctrl.illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module      : control_unit
// Description : ID-stage main control decoder with ID/EX pipeline register,
//               stall-hold and flush-to-bubble (flush > stall > load).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit
    import rv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruc,
    input  logic        stall,
    input  logic        flush,
    output logic [1:0]  ALUOp,
    output logic        ALUSrc,
    output logic        branch,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        illegal
);

    ctrl_t w_dec;
    ctrl_t w_ctrl_d;
    ctrl_t r_ctrl_q;
    logic  w_unused_bits;

    // Only the opcode field steers the decode; the rest is deliberately dropped.
    assign w_unused_bits = ^instruc[31:7];

    control_decode u_decode (
        .i_opcode (instruc[6:0]),
        .o_ctrl   (w_dec)
    );

    always_comb begin
        w_ctrl_d = r_ctrl_q;
        if (flush) begin
            w_ctrl_d = CTRL_BUBBLE;
        end else if (!stall) begin
            w_ctrl_d = w_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl_q <= CTRL_BUBBLE;
        end else begin
            r_ctrl_q <= w_ctrl_d;
        end
    end

    assign ALUOp      = r_ctrl_q.alu_op;
    assign ALUSrc     = r_ctrl_q.alu_src;
    assign branch     = r_ctrl_q.branch;
    assign mem_read   = r_ctrl_q.mem_read;
    assign mem_write  = r_ctrl_q.mem_write;
    assign reg_write  = r_ctrl_q.reg_write;
    assign mem_to_reg = r_ctrl_q.mem_to_reg;
    assign illegal    = r_ctrl_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module      : tb_control_unit
// Description : Directed-vector self-checking bench for control_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    // Packed as {ALUOp, ALUSrc, branch, mem_read, mem_write, reg_write, mem_to_reg, illegal}
    localparam logic [8:0] C_EXP_ZERO = 9'b00_0000000;
    localparam logic [8:0] C_EXP_LW   = 9'b00_1010110;
    localparam logic [8:0] C_EXP_SW   = 9'b00_1001000;
    localparam logic [8:0] C_EXP_R    = 9'b10_0000100;
    localparam logic [8:0] C_EXP_BEQ  = 9'b01_0100000;
    localparam logic [8:0] C_EXP_ADDI = 9'b11_1000100;
    localparam logic [8:0] C_EXP_ILL  = 9'b00_0000001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruc;
    logic        stall;
    logic        flush;
    logic [1:0]  ALUOp;
    logic        ALUSrc;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instruc    (instruc),
        .stall      (stall),
        .flush      (flush),
        .ALUOp      (ALUOp),
        .ALUSrc     (ALUSrc),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {ALUOp, ALUSrc, branch, mem_read, mem_write, reg_write, mem_to_reg, illegal};
    endfunction

    task automatic check_vec(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    // Drive inputs away from the edge, clock once, sample just after the edge.
    task automatic apply(input logic [31:0] ins, input logic stl, input logic fls,
                         input string tag, input logic [8:0] exp);
        @(negedge clk);
        instruc = ins;
        stall   = stl;
        flush   = fls;
        @(posedge clk);
        #1;
        check_vec(tag, outs(), exp);
    endtask

    function automatic logic [31:0] xop(input logic [6:0] op);
        return {25'bx, op};
    endfunction

    initial begin
        rst_n   = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        instruc = xop(7'h03);

        repeat (3) @(posedge clk);
        #1;
        check_vec("reset_hold", outs(), C_EXP_ZERO);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_vec("reset_release_no_edge", outs(), C_EXP_ZERO);
        @(posedge clk);
        #1;
        check_vec("first_decode_lw", outs(), C_EXP_LW);

        apply(xop(7'h23), 1'b0, 1'b0, "sw",   C_EXP_SW);
        apply(xop(7'h33), 1'b0, 1'b0, "rtype", C_EXP_R);
        apply(xop(7'h63), 1'b0, 1'b0, "beq",  C_EXP_BEQ);
        apply(xop(7'h13), 1'b0, 1'b0, "addi", C_EXP_ADDI);
        apply(xop(7'h03), 1'b0, 1'b0, "lw",   C_EXP_LW);
        apply(32'hFFFF_FF33, 1'b0, 1'b0, "rtype_ones_upper", C_EXP_R);
        apply(32'h0000_0000, 1'b0, 1'b0, "bubble_word", C_EXP_ZERO);
        apply(32'h0000_007F, 1'b0, 1'b0, "illegal_7f", C_EXP_ILL);
        apply(32'hFFFF_FF80, 1'b0, 1'b0, "illegal_00_upper_set", C_EXP_ZERO);
        apply(xop(7'h37), 1'b0, 1'b0, "illegal_lui", C_EXP_ILL);

        // Stall holds the loaded lw for three edges, then R-type loads.
        apply(xop(7'h03), 1'b0, 1'b0, "stall_preload_lw", C_EXP_LW);
        for (int i = 0; i < 3; i++) begin
            apply(32'h0000_00B3, 1'b1, 1'b0, "stall_hold", C_EXP_LW);
        end
        apply(32'h0000_00B3, 1'b0, 1'b0, "stall_release", C_EXP_R);

        // Flush beats stall; plain flush also clears an illegal flag.
        apply(32'h0000_0083, 1'b1, 1'b1, "flush_over_stall", C_EXP_ZERO);
        apply(32'h0000_007F, 1'b0, 1'b0, "illegal_again", C_EXP_ILL);
        apply(32'h0000_0083, 1'b0, 1'b1, "flush_clears_illegal", C_EXP_ZERO);
        apply(32'h0000_00E3, 1'b1, 1'b0, "stall_holds_bubble", C_EXP_ZERO);

        // Asynchronous reset between edges while R-type is registered.
        apply(xop(7'h33), 1'b0, 1'b0, "rtype_before_async", C_EXP_R);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("async_reset_no_edge", outs(), C_EXP_ZERO);
        @(posedge clk);
        #1;
        check_vec("async_reset_held", outs(), C_EXP_ZERO);
        @(negedge clk);
        instruc = xop(7'h23);
        rst_n   = 1'b1;
        #1;
        check_vec("async_release_no_edge", outs(), C_EXP_ZERO);
        @(posedge clk);
        #1;
        check_vec("async_release_decode_sw", outs(), C_EXP_SW);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
